// File: rtl/endpoint_flit_tx.sv
// Endpoint flit injector: small flit FIFO, per-VC credit counters and a packet VC lock in front of the switch ingress.
// Defining ENDPOINT_TX_STATS_EN adds the flits_sent / stall_cycles counters.
package endpoint_flit_tx_pkg;
  localparam int VC_W   = 2;
  localparam int DATA_W = 32;
  typedef struct packed {
    logic [VC_W-1:0]   vc;
    logic [DATA_W-1:0] data;
  } flit_t;
endpackage

module endpoint_flit_tx_credit #(
  parameter int CREDITS = 4,
  parameter int CW      = 3
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [CW-1:0] count_o,
  output logic          ovf_o
);
  localparam logic [CW-1:0] MAX_C = CW'(CREDITS);
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_o = 1'b0;
    if (inc_i && !dec_i) begin
      if (cnt_q == MAX_C) ovf_o = 1'b1;
      else                cnt_d = cnt_q + CW'(1);
    end else if (dec_i && !inc_i) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) cnt_q <= MAX_C;
    else        cnt_q <= cnt_d;

  assign count_o = cnt_q;
endmodule

module endpoint_flit_tx
  import endpoint_flit_tx_pkg::*;
#(
  parameter int NUM_VCS    = 2,
  parameter int CREDITS    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 n_rst,
  input  flit_t                                flit_in,
  input  logic                                 flit_valid,
  input  logic                                 flit_last,
  output logic                                 flit_ready,
  output flit_t                                in,
  output logic                                 data_ready_in,
  output logic                                 packet_sent,
  input  logic [NUM_VCS-1:0]                   buffer_available,
  output logic [NUM_VCS*$clog2(CREDITS+1)-1:0] credit_count,
  output logic                                 credit_overflow,
  output logic                                 vc_error
`ifdef ENDPOINT_TX_STATS_EN
  ,
  output logic [31:0]                          flits_sent,
  output logic [31:0]                          stall_cycles
`endif
);
  localparam int CW = $clog2(CREDITS+1);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int VI = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;
  localparam logic [AW:0] DEPTH_C = FIFO_DEPTH;

  typedef enum logic {IDLE, PKT} state_t;
  typedef struct packed {
    flit_t flit;
    logic  last;
  } entry_t;

  entry_t                      mem_q [FIFO_DEPTH];
  logic [AW-1:0]               wr_ptr_q, rd_ptr_q;
  logic [AW:0]                 cnt_q;
  logic                        full, empty, push, issue;
  entry_t                      head;
  logic [VI-1:0]               head_vc;
  flit_t                       out_flit;
  logic [NUM_VCS-1:0][CW-1:0]  credit;
  logic [NUM_VCS-1:0]          dec, ovf;

  state_t                      state_q;
  logic [VC_W-1:0]             locked_vc_q;
  flit_t                       in_q;
  logic                        dri_q, ps_q, ovf_q, vc_err_q;

  assign full       = (cnt_q == DEPTH_C);
  assign empty      = (cnt_q == '0);
  assign flit_ready = !full;
  assign push       = flit_valid && !full;
  assign head       = mem_q[rd_ptr_q];

  // Mid-packet the head is charged to the locked VC, whatever its own tag says.
  assign head_vc = (state_q == PKT) ? locked_vc_q[VI-1:0] : head.flit.vc[VI-1:0];
  assign issue   = !empty && (credit[head_vc] != '0);

  always_comb begin
    out_flit = head.flit;
    if (state_q == PKT) out_flit.vc = locked_vc_q;
  end

  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q] <= {flit_in, flit_last};

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push)  wr_ptr_q <= wr_ptr_q + AW'(1);
      if (issue) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, issue})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
    assign dec[v] = issue && (head_vc == VI'(v));
    endpoint_flit_tx_credit #(.CREDITS(CREDITS), .CW(CW)) u_credit (
      .clk     (clk),
      .n_rst   (n_rst),
      .inc_i   (buffer_available[v]),
      .dec_i   (dec[v]),
      .count_o (credit[v]),
      .ovf_o   (ovf[v])
    );
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      locked_vc_q <= '0;
      in_q        <= '0;
      dri_q       <= 1'b0;
      ps_q        <= 1'b0;
      ovf_q       <= 1'b0;
      vc_err_q    <= 1'b0;
    end else begin
      ovf_q <= ovf_q | (|ovf);
      dri_q <= issue;
      ps_q  <= issue && head.last;
      if (issue) begin
        in_q <= out_flit;
        case (state_q)
          IDLE: if (!head.last) begin
            locked_vc_q <= head.flit.vc;
            state_q     <= PKT;
          end
          PKT: begin
            if (head.flit.vc != locked_vc_q) vc_err_q <= 1'b1;
            if (head.last) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign in              = in_q;
  assign data_ready_in   = dri_q;
  assign packet_sent     = ps_q;
  assign credit_count    = credit;
  assign credit_overflow = ovf_q;
  assign vc_error        = vc_err_q;

`ifdef ENDPOINT_TX_STATS_EN
  logic [31:0] sent_q, stall_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sent_q  <= '0;
      stall_q <= '0;
    end else begin
      if (dri_q)            sent_q  <= sent_q + 32'd1;
      if (!empty && !issue) stall_q <= stall_q + 32'd1;
    end
  end

  assign flits_sent   = sent_q;
  assign stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_endpoint_flit_tx.sv
// Scoreboard bench for endpoint_flit_tx: stimulus pushes expected output flits, a negedge monitor pops and compares.
module tb_endpoint_flit_tx;
  import endpoint_flit_tx_pkg::*;
  localparam int NV = 2, CR = 4, FD = 4, CW = $clog2(CR+1);

  typedef struct packed {
    flit_t f;
    logic  last;
  } exp_t;

  logic                clk = 1'b0, n_rst = 1'b0;
  flit_t               flit_in = '0, in_w;
  logic                flit_valid = 1'b0, flit_last = 1'b0;
  logic                flit_ready, dri, ps, covf, vcerr;
  logic [NV-1:0]       man_ba = '0, auto_ba = '0, ba;
  logic [NV*CW-1:0]    cc;

  assign ba = man_ba | auto_ba;
  always #5 clk = ~clk;

  endpoint_flit_tx #(.NUM_VCS(NV), .CREDITS(CR), .FIFO_DEPTH(FD)) dut (
    .clk              (clk),
    .n_rst            (n_rst),
    .flit_in          (flit_in),
    .flit_valid       (flit_valid),
    .flit_last        (flit_last),
    .flit_ready       (flit_ready),
    .in               (in_w),
    .data_ready_in    (dri),
    .packet_sent      (ps),
    .buffer_available (ba),
    .credit_count     (cc),
    .credit_overflow  (covf),
    .vc_error         (vcerr)
  );

  exp_t expq[$];
  exp_t mon_e;
  int   vectors = 0, errors = 0;
  int   n_out = 0, n_base = 0;
  int   owed[NV];
  bit   auto_ret = 0;
  bit   m_lock = 0, m_vcerr = 0;
  logic [VC_W-1:0] m_lk = '0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] credits_of(int v);
    logic [NV*CW-1:0] t;
    t = cc >> (v*CW);
    return 64'(t[CW-1:0]);
  endfunction

  // Monitor: returns owed credits (random switch drain) and scores every emitted flit.
  always @(negedge clk) begin
    if (!n_rst) begin
      expq.delete();
      for (int v = 0; v < NV; v++) owed[v] = 0;
      auto_ba = '0;
    end else begin
      for (int v = 0; v < NV; v++) begin
        if (auto_ret && owed[v] > 0 && $urandom_range(1, 0) == 1) begin
          auto_ba[v] = 1'b1;
          owed[v]--;
        end else begin
          auto_ba[v] = 1'b0;
        end
      end
      if (dri) begin
        n_out++;
        if (expq.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_flit: got %0h, expected none", in_w);
        end else begin
          mon_e = expq.pop_front();
          chk("flit_out", 64'(in_w), 64'(mon_e.f));
          chk("packet_sent", 64'(ps), 64'(mon_e.last));
        end
        if (auto_ret) owed[int'(in_w.vc)]++;
      end
    end
  end

  // Reference: order is preserved, a packet's flits all leave on the VC its head carried.
  task automatic model_push(flit_t f, logic last);
    exp_t e;
    e.f    = f;
    e.last = last;
    if (m_lock) begin
      if (f.vc != m_lk) m_vcerr = 1;
      e.f.vc = m_lk;
      if (last) m_lock = 0;
    end else if (!last) begin
      m_lock = 1;
      m_lk   = f.vc;
    end
    expq.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the flit is accepted.
  task automatic send(int vc, logic last);
    int t = 0;
    flit_in.vc   = vc[VC_W-1:0];
    flit_in.data = $urandom;
    flit_last    = last;
    flit_valid   = 1'b1;
    while (!flit_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!flit_ready) begin
      vectors++;
      errors++;
      $display("FAIL send_timeout: got flit_ready=0, expected 1 within 300 cycles");
      flit_valid = 1'b0;
      return;
    end
    model_push(flit_in, last);
    @(posedge clk);
    @(negedge clk);
    flit_valid = 1'b0;
  endtask

  task automatic do_reset();
    flit_valid = 1'b0;
    man_ba     = '0;
    auto_ret   = 0;
    n_rst      = 1'b0;
    m_lock     = 0;
    m_vcerr    = 0;
    repeat (2) @(negedge clk);
    n_rst  = 1'b1;
    n_base = n_out;
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int owed_sum, t;

    // Reset state
    @(negedge clk);
    chk("rst_flit_ready", 64'(flit_ready), 64'd1);
    chk("rst_dri", 64'(dri), 64'd0);
    chk("rst_packet_sent", 64'(ps), 64'd0);
    chk("rst_in", 64'(in_w), 64'd0);
    chk("rst_credits", 64'(cc), 64'({3'd4, 3'd4}));
    chk("rst_flags", 64'({covf, vcerr}), 64'd0);
    n_rst = 1'b1;
    @(negedge clk);

    // 3-flit packet on VC1: latency N+2, packet_sent only on tail
    send(1, 1'b0);
    chk("lat_not_early", 64'(dri), 64'd0);
    send(1, 1'b0);
    chk("lat_first_dri", 64'(dri), 64'd1);
    chk("lat_first_ps", 64'(ps), 64'd0);
    send(1, 1'b1);
    chk("pkt_mid_dri", 64'(dri), 64'd1);
    chk("pkt_mid_ps", 64'(ps), 64'd0);
    idle(1);
    chk("pkt_tail_dri", 64'(dri), 64'd1);
    chk("pkt_tail_ps", 64'(ps), 64'd1);
    idle(4);
    chk("pkt_credits_vc1", credits_of(1), 64'd1);
    chk("pkt_credits_vc0", credits_of(0), 64'd4);

    // 6 singles on VC0 with no returns, then fill the FIFO, then one credit return
    do_reset();
    for (int i = 0; i < 6; i++) send(0, 1'b1);
    idle(8);
    chk("stall_sent", 64'(n_out - n_base), 64'd4);
    chk("stall_credits", credits_of(0), 64'd0);
    send(0, 1'b1);
    send(0, 1'b1);
    chk("full_not_ready", 64'(flit_ready), 64'd0);
    man_ba[0] = 1'b1;
    @(negedge clk);
    man_ba[0] = 1'b0;
    idle(6);
    chk("ret_one_more", 64'(n_out - n_base), 64'd5);
    chk("ret_credits", credits_of(0), 64'd0);
    chk("ret_ready", 64'(flit_ready), 64'd1);

    // Issue and credit return in the same cycle at 2 credits
    do_reset();
    send(0, 1'b1);
    send(0, 1'b1);
    idle(6);
    chk("pre_simul_credits", credits_of(0), 64'd2);
    send(0, 1'b1);
    man_ba[0] = 1'b1;
    @(negedge clk);
    man_ba[0] = 1'b0;
    idle(4);
    chk("simul_credits", credits_of(0), 64'd2);

    // Credit return at full credits
    do_reset();
    man_ba[1] = 1'b1;
    @(negedge clk);
    man_ba[1] = 1'b0;
    idle(1);
    chk("ovf_credits", credits_of(1), 64'd4);
    chk("ovf_flag", 64'(covf), 64'd1);
    idle(5);
    chk("ovf_sticky", 64'(covf), 64'd1);

    // Mid-packet VC mismatch, then reset in the middle of a packet
    do_reset();
    send(0, 1'b0);
    send(1, 1'b1);
    idle(5);
    chk("vcerr_flag", 64'(vcerr), 64'(m_vcerr));
    send(0, 1'b0);
    send(0, 1'b0);
    send(0, 1'b0);
    send(0, 1'b0);
    do_reset();
    chk("mid_rst_ready", 64'(flit_ready), 64'd1);
    chk("mid_rst_credits", 64'(cc), 64'({3'd4, 3'd4}));
    chk("mid_rst_flags", 64'({covf, vcerr}), 64'd0);
    idle(6);
    chk("mid_rst_no_out", 64'(n_out - n_base), 64'd0);
    send(1, 1'b1);
    idle(4);
    chk("post_rst_single", 64'(n_out - n_base), 64'd1);

    // Random traffic with a switch that drains and returns credits at random
    do_reset();
    auto_ret = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3, 0) == 0) idle(1);
      else send(int'($urandom_range(NV-1, 0)), ($urandom_range(2, 0) == 0));
    end
    t = 0;
    do begin
      @(negedge clk);
      owed_sum = 0;
      for (int v = 0; v < NV; v++) owed_sum += owed[v];
      t++;
    end while ((expq.size() != 0 || owed_sum != 0) && t < 5000);
    chk("rand_drained", 64'(expq.size() + owed_sum), 64'd0);
    idle(3);
    chk("rand_credits", 64'(cc), 64'({3'd4, 3'd4}));
    chk("rand_vcerr", 64'(vcerr), 64'(m_vcerr));
    chk("rand_ovf", 64'(covf), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/endpoint_flit_tx.md
Name: endpoint_flit_tx

Overview:
- Endpoint-side injector that drives the switch ingress of the switch interface (`in`, `data_ready_in`, `packet_sent`) from a local flit source.
- Buffers flits in a small FIFO and tracks per-VC credits returned via `buffer_available`.
- Issues a flit only when its VC holds a credit, so the switch input buffer never overflows.
- One instance per endpoint link, between the endpoint packetizer and the switch.

Parameters:
- NUM_VCS, 2: virtual channels on the link; equals the switch NUM_VCS.
- CREDITS, 4: flit slots per VC in the switch input buffer; also the reset credit count.
- FIFO_DEPTH, 4: local flit FIFO entries; power of two, ≥2.

Ports:
- clk  input  1  clock
- n_rst  input  1  async active-low reset
- flit_in  input  flit_t  flit from packetizer; VC taken from flit_in.vc
- flit_valid  input  1  flit_in valid
- flit_last  input  1  flit_in is tail of packet
- flit_ready  output  1  FIFO can accept (not full)
- in  output  flit_t  flit to switch ingress
- data_ready_in  output  1  one-cycle strobe: `in` valid this cycle
- packet_sent  output  1  one-cycle pulse coincident with a tail flit on `in`
- buffer_available  input  NUM_VCS  per-VC credit-return pulse, one credit per set bit per cycle
- credit_count  output  NUM_VCS*$clog2(CREDITS+1)  current credits per VC
- credit_overflow  output  1  sticky: credit returned to a VC already at CREDITS
- vc_error  output  1  sticky: mid-packet flit carried a VC other than the locked VC

Behaviour:
- Reset (async, n_rst=0):
  - FIFO empty, flit_ready=1.
  - in=0, data_ready_in=0, packet_sent=0.
  - Every credit counter = CREDITS.
  - credit_overflow=0, vc_error=0.
  - FSM = IDLE.
- Reset mid-operation discards FIFO contents and any partially sent packet. No flit is emitted after reset until the FIFO is written again.
- Enqueue:
  - Occurs when flit_valid && flit_ready.
  - Stores {flit, last}.
  - flit_ready = !full, combinational from the registered count.
  - If the FIFO is full, flit_valid is ignored and nothing is lost from the FIFO; the source must hold the flit.
- Issue condition, evaluated each cycle: FIFO not empty && credit[head_vc] > 0, where head_vc = locked_vc in PKT, else head.vc.
- Issue effects (all registered):
  - Pop head.
  - Next cycle: in=head flit, data_ready_in=1, packet_sent=head.last.
  - Otherwise data_ready_in=0, packet_sent=0, and `in` holds its last value.
- Latency: a flit enqueued in cycle N into an empty FIFO with credit available appears on `in` in cycle N+2 (write in N, issue in N+1, registered output in N+2).
- Throughput: 1 flit/cycle while credits last.
- Credits, per VC v:
  - Decrement on issue to v; increment on buffer_available[v].
  - Both in the same cycle: unchanged.
  - Return at CREDITS with no issue: counter stays CREDITS, credit_overflow set.
  - Issue at 0 credits is impossible by construction.
- FSM (packet VC lock):
  - IDLE: on issue of a non-last flit, locked_vc ← flit.vc, go to PKT. On issue of a last flit (single-flit packet), stay in IDLE.
  - PKT: every issued flit is sent on locked_vc; the output flit's vc field is overwritten with locked_vc. If head.vc ≠ locked_vc, vc_error is set. On issue of a last flit, go to IDLE.
- Stall: the head is blocked while its VC has 0 credits. Flits behind it wait (no reordering, no VC bypass).
- FIFO pointers wrap modulo FIFO_DEPTH. Simultaneous enqueue and dequeue at full is allowed only if the dequeue frees the slot. flit_ready is evaluated before the pop, so at full flit_ready=0 that cycle.

Optional Feature:
- Macro: ENDPOINT_TX_STATS_EN.
- Defined: adds outputs `flits_sent` (32 bits, +1 per data_ready_in) and `stall_cycles` (32 bits, +1 per cycle the FIFO is non-empty and the head VC has 0 credits). Both reset to 0 and wrap at 2^32.
- Undefined: both ports and their counters are absent; all other behaviour is identical.

Test Plan:
- Reset → flit_ready=1, data_ready_in=0, every credit_count=4, flags 0.
- 3-flit packet on VC1 (last on 3rd), no returns → flits on `in` in cycles N+2..N+4; packet_sent only at N+4; credit_count[VC1]=1.
- 6 single-flit packets on VC0, no returns → 4 sent, 2 stall, credit_count[VC0]=0, flit_ready low once FIFO fills. Pulse buffer_available[0] once → exactly one more flit, credits stay 0.
- Simultaneous issue on VC0 and buffer_available[0] with credits=2 → credits remain 2.
- buffer_available[1] pulse with credit_count[1]=4 → count stays 4, credit_overflow=1 and sticky.
- Packet head on VC0, second flit tagged VC1 → second flit emitted with vc=0, vc_error=1. Assert n_rst mid-packet → FIFO empty, FSM IDLE, credits=4, no further data_ready_in.
